phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The port list SHALL be as follows, clock and reset first:
- clk        input   1   sole clock; all state updates on the rising edge.
- rst_n      input   1   asynchronous, active-low reset.
- start      input   1   level-sampled request to run continuously or to resume from HALTED.
- step       input   1   level-sampled request to execute exactly one instruction.
- stop       input   1   request to leave RUN at the next instruction boundary.
- halt       input   1   halt strobe from the controller decode.
- mem_ready  input   1   memory ready; low stalls phase advance.
- phase      output  3   current instruction phase, 0..7, fed to the controller.
- state      output  2   sequencer state: IDLE=0, RUN=1, STEP=2, HALTED=3.
- halted     output  1   high while state==HALTED.
- busy       output  1   high while state is RUN or STEP.
- icount     output  16  count of completed instructions.

Function
REQ-002 The block SHALL be a 4-state Moore FSM with states IDLE, RUN, STEP and HALTED.
REQ-003 phase SHALL advance by 1 per clock, wrapping 7->0, only when busy==1 and mem_ready==1.
REQ-004 When mem_ready==0, phase, state and icount SHALL hold; a stall SHALL NOT drop any pending transition.
REQ-005 In IDLE, phase SHALL be 0:
- start==1 -> RUN.
- else step==1 -> STEP.
- If both are high, start wins.
REQ-006 The 7->0 phase wrap SHALL increment icount by 1, modulo 2^16, with no saturation.
REQ-007 In RUN:
- stop==1, sampled at any point, SHALL set an internal stop-pending flag.
- At the next 7->0 wrap, state SHALL go to IDLE and the flag SHALL clear.
REQ-008 In STEP, the wrap 7->0 SHALL return state to IDLE with phase=0; start and step SHALL be ignored while in STEP.
REQ-009 In RUN or STEP, halt==1 while phase==4 and mem_ready==1 SHALL move state to HALTED:
- phase SHALL freeze at 4.
- icount SHALL NOT increment.
REQ-010 halt SHALL be ignored in any phase other than 4 and in the IDLE and HALTED states.
REQ-011 In HALTED, start==1 SHALL move state to RUN with phase advancing to 5 on the same edge; step and stop SHALL be ignored.
REQ-012 halt at phase 4 in the same cycle as a pending stop SHALL go to HALTED, and the stop-pending flag SHALL clear.
REQ-013 Outputs SHALL be registered or decoded only from registered state; there SHALL be no combinational path from any input to any output.
REQ-014 Latency:
- start or step high in IDLE -> busy=1 on the next clock edge.
- The first phase advance occurs one edge after busy rises.

Reset
REQ-015 While rst_n==0, regardless of clk:
- state=IDLE, phase=0, icount=0.
- halted=0, busy=0, stop-pending=0.
REQ-016 Reset asserted mid-instruction SHALL abandon that instruction without incrementing icount.
REQ-017 After rst_n deasserts, the block SHALL stay in IDLE until start or step is sampled high.

Structure
REQ-018 The shared package vr_pkg SHALL hold:
- the phase encodings INST_ADDR=0 through STORE=7;
- the state encodings IDLE/RUN/STEP/HALTED;
- the widths PHASE_W=3 and ICOUNT_W=16.
REQ-019 The design SHALL be a single module with no sub-modules; the phase counter and FSM SHALL live in the same block.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, pulse start 1 cycle, mem_ready=1, 16 cycles -> phase sequence 0..7,0..7; icount=2; busy=1.
- step in IDLE, no halt -> exactly 8 phase advances, then state=IDLE, phase=0, icount=1; a start pulse during STEP has no effect.
- RUN, halt=1 held during phase 4 -> state=HALTED, phase stays 4 for 10 cycles, icount unchanged; start -> phase=5, then completes, icount+1.
- RUN, mem_ready=0 for 3 cycles at phase 2 -> phase holds at 2 for 3 cycles, then resumes at 3; no icount change.
- RUN, stop pulse at phase 3 -> phases 4..7 complete, then state=IDLE, phase=0; stop together with halt at phase 4 -> HALTED.
- icount preset via 65535 instructions, then one more -> icount=0; rst_n low at phase 5 -> phase=0, icount=0 immediately.

Source files
------------

// File: rtl/vr_pkg.sv
// ---------------------------------------------------------------------------
// vr_pkg
// Shared definitions for the instruction phase sequencer and its controller:
//   - phase encodings (INST_ADDR=0 .. STORE=7)
//   - sequencer state encodings (IDLE/RUN/STEP/HALTED)
//   - widths PHASE_W and ICOUNT_W
//   - phase_next(): modulo-8 phase increment
// ---------------------------------------------------------------------------
package vr_pkg;

   localparam int PHASE_W  = 3;
   localparam int ICOUNT_W = 16;

   typedef enum logic [PHASE_W-1:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      DECODE     = 3'd2,
      OPER_ADDR  = 3'd3,
      OPER_FETCH = 3'd4,
      EXECUTE    = 3'd5,
      WRITEBACK  = 3'd6,
      STORE      = 3'd7
   } phase_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2,
      HALTED = 2'd3
   } state_e;

   // The only phase at which a halt strobe from decode is honoured.
   localparam phase_e HALT_PHASE = OPER_FETCH;

   // Wraps STORE -> INST_ADDR naturally through the 3-bit add.
   function automatic phase_e phase_next(input phase_e p);
      return phase_e'(p + 3'd1);
   endfunction

endpackage

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
// Steps the controller through the eight phases of each instruction and
// tracks the run/step/halt state of the machine.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   run continuously (from IDLE) or resume (from HALTED)
//   step       in   execute exactly one instruction (from IDLE)
//   stop       in   leave RUN at the next instruction boundary
//   halt       in   halt strobe from decode, honoured at phase 4 only
//   mem_ready  in   low freezes all sequencing for that cycle
//   phase      out  current instruction phase 0..7
//   state      out  IDLE=0, RUN=1, STEP=2, HALTED=3
//   halted     out  state == HALTED
//   busy       out  state is RUN or STEP
//   icount     out  completed-instruction count, wraps modulo 2^16
// ---------------------------------------------------------------------------
module phase_sequencer
   import vr_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                step,
   input  logic                stop,
   input  logic                halt,
   input  logic                mem_ready,
   output logic [PHASE_W-1:0]  phase,
   output logic [1:0]          state,
   output logic                halted,
   output logic                busy,
   output logic [ICOUNT_W-1:0] icount
);

   state_e               state_r;
   phase_e               phase_r;
   logic [ICOUNT_W-1:0]  icount_r;
   logic                 stop_pend_r;

   logic at_wrap;
   logic halt_hit;
   logic stop_seen;

   assign at_wrap   = (phase_r == STORE);
   assign halt_hit  = halt && (phase_r == HALT_PHASE);
   // A stop arriving on the boundary cycle itself still ends the run there.
   assign stop_seen = stop_pend_r | stop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         phase_r     <= INST_ADDR;
         icount_r    <= '0;
         stop_pend_r <= 1'b0;
      end else begin
         unique case (state_r)
            IDLE: begin
               // phase is already INST_ADDR here: IDLE is only entered on a wrap or reset.
               if (mem_ready) begin
                  if (start) begin
                     state_r <= RUN;
                  end else if (step) begin
                     state_r <= STEP;
                  end
               end
            end

            RUN: begin
               // Capture stop even during a stall so the request is never lost.
               if (stop) begin
                  stop_pend_r <= 1'b1;
               end
               if (mem_ready) begin
                  if (halt_hit) begin
                     state_r     <= HALTED;
                     stop_pend_r <= 1'b0;
                  end else begin
                     phase_r <= phase_next(phase_r);
                     if (at_wrap) begin
                        icount_r <= icount_r + ICOUNT_W'(1);
                        if (stop_seen) begin
                           state_r     <= IDLE;
                           stop_pend_r <= 1'b0;
                        end
                     end
                  end
               end
            end

            STEP: begin
               if (mem_ready) begin
                  if (halt_hit) begin
                     state_r <= HALTED;
                  end else begin
                     phase_r <= phase_next(phase_r);
                     if (at_wrap) begin
                        icount_r <= icount_r + ICOUNT_W'(1);
                        state_r  <= IDLE;
                     end
                  end
               end
            end

            HALTED: begin
               // Resume continues the frozen instruction, so phase moves 4 -> 5 now.
               if (mem_ready && start) begin
                  state_r <= RUN;
                  phase_r <= phase_next(phase_r);
               end
            end
         endcase
      end
   end

   assign phase  = phase_r;
   assign state  = state_r;
   assign icount = icount_r;
   assign halted = (state_r == HALTED);
   assign busy   = (state_r == RUN) || (state_r == STEP);

endmodule

// File: tb/tb_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phase_sequencer
// Self-checking bench for phase_sequencer: a fixed vector table, directed
// multi-cycle sequences and randomized stimulus against a behavioural model.
// ---------------------------------------------------------------------------
module tb_phase_sequencer;

   localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_HALTED = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, step = 1'b0, stop = 1'b0, halt = 1'b0, mem_ready = 1'b0;
   logic [2:0]  phase;
   logic [1:0]  state;
   logic        halted, busy;
   logic [15:0] icount;

   int total = 0;
   int bad   = 0;

   // behavioural model
   int m_state, m_phase, m_icount;
   bit m_stop;

   phase_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop),
      .halt(halt), .mem_ready(mem_ready), .phase(phase), .state(state),
      .halted(halted), .busy(busy), .icount(icount)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit s, st, sp, h, mr;
      int ph, sta, ic;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mkv(bit s, bit st, bit sp, bit h, bit mr, int ph, int sta, int ic);
      vec_t v;
      v.s = s; v.st = st; v.sp = sp; v.h = h; v.mr = mr;
      v.ph = ph; v.sta = sta; v.ic = ic;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // One clock of the sequencer, stated in terms of instructions and phases.
   task automatic model_clock(input bit s, input bit st, input bit sp, input bit h, input bit mr);
      bit pend;
      pend = m_stop || (m_state == S_RUN && sp);
      if (mr) begin
         if (m_state == S_IDLE) begin
            if (s) m_state = S_RUN;
            else if (st) m_state = S_STEP;
         end else if (m_state == S_HALTED) begin
            if (s) begin
               m_state = S_RUN;
               m_phase = 5;
            end
         end else if (h && m_phase == 4) begin
            m_state = S_HALTED;
            pend = 0;
         end else begin
            m_phase = (m_phase + 1) % 8;
            if (m_phase == 0) begin
               m_icount = (m_icount + 1) % 65536;
               if (m_state == S_STEP || pend) begin
                  m_state = S_IDLE;
                  pend = 0;
               end
            end
         end
      end
      m_stop = pend;
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_phase = 0; m_icount = 0; m_stop = 0;
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, "_phase"},  int'(phase),  m_phase);
      chk({tag, "_state"},  int'(state),  m_state);
      chk({tag, "_icount"}, int'(icount), m_icount);
      chk({tag, "_busy"},   int'(busy),   int'(m_state == S_RUN || m_state == S_STEP));
      chk({tag, "_halted"}, int'(halted), int'(m_state == S_HALTED));
   endtask

   task automatic cyc(input bit s, input bit st, input bit sp, input bit h, input bit mr);
      @(negedge clk);
      start = s; step = st; stop = sp; halt = h; mem_ready = mr;
      @(posedge clk);
      model_clock(s, st, sp, h, mr);
      #1;
      cmp_model("model");
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_phase"},  int'(phase),  0);
      chk({tag, "_state"},  int'(state),  0);
      chk({tag, "_icount"}, int'(icount), 0);
      chk({tag, "_busy"},   int'(busy),   0);
      chk({tag, "_halted"}, int'(halted), 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      start = 0; step = 0; stop = 0; halt = 0; mem_ready = 1;
      #1;
      model_reset();
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // args: start step stop halt mem_ready | phase state icount
      tbl[0]  = mkv(1,0,0,0,0, 0,0,0);  // stalled: start must wait
      tbl[1]  = mkv(1,1,0,0,1, 0,1,0);  // start beats step
      tbl[2]  = mkv(0,0,0,1,1, 1,1,0);  // halt at phase 0 ignored
      tbl[3]  = mkv(0,0,0,0,1, 2,1,0);
      tbl[4]  = mkv(0,0,1,0,0, 2,1,0);  // stop during stall is kept
      tbl[5]  = mkv(0,0,0,0,1, 3,1,0);
      tbl[6]  = mkv(0,0,0,0,1, 4,1,0);
      tbl[7]  = mkv(0,0,0,1,0, 4,1,0);  // halt needs mem_ready
      tbl[8]  = mkv(0,0,0,0,1, 5,1,0);
      tbl[9]  = mkv(0,0,0,0,1, 6,1,0);
      tbl[10] = mkv(0,0,0,0,1, 7,1,0);
      tbl[11] = mkv(0,0,0,0,1, 0,0,1);  // pending stop ends run
      tbl[12] = mkv(0,1,0,0,1, 0,2,1);
      tbl[13] = mkv(0,0,0,0,1, 1,2,1);
      tbl[14] = mkv(0,0,0,0,1, 2,2,1);
      tbl[15] = mkv(0,0,0,0,1, 3,2,1);
      tbl[16] = mkv(0,0,0,0,1, 4,2,1);
      tbl[17] = mkv(0,0,0,1,1, 4,3,1);  // halt while stepping
      tbl[18] = mkv(0,1,1,0,1, 4,3,1);  // step/stop ignored in HALTED
      tbl[19] = mkv(1,0,0,0,1, 5,1,1);  // resume goes straight to 5

      model_reset();
      #1;
      check_reset_vals("por");
      apply_reset();

      // -------- vector table
      for (int i = 0; i < 20; i++) begin
         cyc(tbl[i].s, tbl[i].st, tbl[i].sp, tbl[i].h, tbl[i].mr);
         chk($sformatf("tbl%0d_phase", i),  int'(phase),  tbl[i].ph);
         chk($sformatf("tbl%0d_state", i),  int'(state),  tbl[i].sta);
         chk($sformatf("tbl%0d_icount", i), int'(icount), tbl[i].ic);
      end

      // -------- 1: start pulse, 16 cycles of continuous run
      apply_reset();
      cyc(1,0,0,0,1);
      chk("s1_busy_rise", int'(busy), 1);
      chk("s1_first_phase", int'(phase), 0);
      for (int i = 1; i <= 16; i++) begin
         cyc(0,0,0,0,1);
         chk($sformatf("s1_phase_%0d", i), int'(phase), i % 8);
      end
      chk("s1_icount", int'(icount), 2);
      chk("s1_busy", int'(busy), 1);
      cyc(0,0,1,0,1);
      for (int i = 0; i < 7; i++) cyc(0,0,0,0,1);
      chk("s1_stop_state", int'(state), S_IDLE);
      chk("s1_stop_phase", int'(phase), 0);
      chk("s1_stop_icount", int'(icount), 3);

      // -------- 2: single step with a start pulse inside
      cyc(0,1,0,0,1);
      chk("s2_state_step", int'(state), S_STEP);
      for (int i = 1; i <= 8; i++) begin
         cyc(i == 3, 0,0,0,1);
         if (i < 8) begin
            chk($sformatf("s2_state_%0d", i), int'(state), S_STEP);
            chk($sformatf("s2_phase_%0d", i), int'(phase), i);
         end
      end
      chk("s2_end_state", int'(state), S_IDLE);
      chk("s2_end_phase", int'(phase), 0);
      chk("s2_end_icount", int'(icount), 4);

      // -------- 3: halt at phase 4, hold, resume
      cyc(1,0,0,0,1);
      for (int i = 0; i < 4; i++) cyc(0,0,0,0,1);
      chk("s3_pre_phase", int'(phase), 4);
      cyc(0,0,0,1,1);
      chk("s3_halted_state", int'(state), S_HALTED);
      for (int i = 0; i < 10; i++) begin
         cyc(0, i == 5, i == 6, 1, 1);
         chk($sformatf("s3_hold_phase_%0d", i), int'(phase), 4);
         chk($sformatf("s3_hold_halted_%0d", i), int'(halted), 1);
      end
      chk("s3_hold_icount", int'(icount), 4);
      cyc(1,0,0,0,1);
      chk("s3_resume_state", int'(state), S_RUN);
      chk("s3_resume_phase", int'(phase), 5);
      for (int i = 0; i < 3; i++) cyc(0,0,0,0,1);
      chk("s3_done_phase", int'(phase), 0);
      chk("s3_done_icount", int'(icount), 5);

      // -------- 4: stall at phase 2
      cyc(0,0,0,0,1);
      cyc(0,0,0,0,1);
      for (int i = 0; i < 3; i++) begin
         cyc(0,0,0,0,0);
         chk($sformatf("s4_stall_phase_%0d", i), int'(phase), 2);
      end
      cyc(0,0,0,0,1);
      chk("s4_resume_phase", int'(phase), 3);
      chk("s4_icount", int'(icount), 5);

      // -------- 5: stop at phase 3; then stop together with halt
      cyc(0,0,1,0,1);
      chk("s5_after_stop_state", int'(state), S_RUN);
      for (int i = 0; i < 4; i++) begin
         cyc(0,0,0,0,1);
         if (i < 3) chk($sformatf("s5_run_state_%0d", i), int'(state), S_RUN);
      end
      chk("s5_stop_state", int'(state), S_IDLE);
      chk("s5_stop_phase", int'(phase), 0);
      chk("s5_stop_icount", int'(icount), 6);
      cyc(1,0,0,0,1);
      for (int i = 0; i < 4; i++) cyc(0,0,0,0,1);
      cyc(0,0,1,1,1);
      chk("s5_sh_state", int'(state), S_HALTED);
      chk("s5_sh_phase", int'(phase), 4);
      cyc(1,0,0,0,1);
      for (int i = 0; i < 3; i++) cyc(0,0,0,0,1);
      chk("s5_pend_cleared_state", int'(state), S_RUN);
      chk("s5_pend_cleared_icount", int'(icount), 7);

      // -------- 6: icount wrap, then reset mid-instruction
      force dut.icount_r = 16'hFFFF;
      #1;
      release dut.icount_r;
      m_icount = 65535;
      for (int i = 0; i < 8; i++) cyc(0,0,0,0,1);
      chk("s6_wrap_icount", int'(icount), 0);
      chk("s6_wrap_phase", int'(phase), 0);
      for (int i = 0; i < 5; i++) cyc(0,0,0,0,1);
      chk("s6_pre_reset_phase", int'(phase), 5);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_vals("s6_async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(0,0,1,1,1);
         chk($sformatf("s6_stay_idle_%0d", i), int'(state), S_IDLE);
      end

      // -------- randomized run against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            apply_reset();
         end else begin
            cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 3,
                $urandom_range(0, 9) < 8);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
